// File: rtl/regfile_cmd_sequencer.sv
// Register-file command sequencer: turns one decoded register-op request into
// the LATCHSEL/READA/READB/exec/write command stream and reports done or error.
module regfile_cmd_sequencer #(
   parameter int INDEX_WIDTH = 3,
   parameter int ALU_TIMEOUT = 15
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_valid,
   output logic                   o_ready,
   input  logic [INDEX_WIDTH-1:0] i_sel_a,
   input  logic [INDEX_WIDTH-1:0] i_sel_b,
   input  logic [INDEX_WIDTH-1:0] i_sel_c,
   input  logic                   i_use_b,
   input  logic [1:0]             i_wsel,
   output logic [3:0]             o_cmd,
   output logic [INDEX_WIDTH-1:0] o_sel_a,
   output logic [INDEX_WIDTH-1:0] o_sel_b,
   output logic [INDEX_WIDTH-1:0] o_sel_c,
   output logic [1:0]             o_alu_wsel,
   output logic                   o_alu_start,
   input  logic                   i_alu_done,
   output logic                   o_done,
   output logic                   o_err
);

   typedef enum logic [3:0] {
      CMD_NOP      = 4'd0,
      CMD_READA    = 4'd1,
      CMD_READB    = 4'd2,
      CMD_LATCHSEL = 4'd4,
      CMD_ALU_WE   = 4'd6,
      CMD_SP_WE    = 4'd7
   } command_t;

   typedef enum logic [1:0] {
      WSEL_NONE = 2'd0,
      WSEL_REGC = 2'd1,
      WSEL_REGF = 2'd2,
      WSEL_RFU  = 2'd3
   } write_sel_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEL,
      ST_RDA,
      ST_RDB,
      ST_EXEC,
      ST_WB
   } state_t;

   localparam int CNT_W = $clog2(ALU_TIMEOUT + 1);
   localparam logic [CNT_W-1:0]       EXEC_LAST = CNT_W'(ALU_TIMEOUT - 1);
   localparam logic [INDEX_WIDTH-1:0] R_ZERO    = '0;
   localparam logic [INDEX_WIDTH-1:0] R_SP      = INDEX_WIDTH'(6);

   state_t                   state_q, state_d;
   logic [INDEX_WIDTH-1:0]   sel_a_q, sel_b_q, sel_c_q;
   logic                     use_b_q;
   write_sel_t               wsel_q;
   logic [CNT_W-1:0]         exec_cnt_q;
   logic                     done_q, err_q;

   command_t                 cmd;
   logic                     alu_start;
   logic                     set_done, set_err;
   logic                     accept;
   logic                     write_to_zero;

   assign accept        = (state_q == ST_IDLE) && i_valid;
   // A REGC write to R_ZERO is architecturally a no-op, so the op ends after EXEC.
   assign write_to_zero = (wsel_q == WSEL_REGC) && (sel_c_q == R_ZERO);

   // NOTE: every signal driven here gets a default first so no path leaves it
   // unassigned; otherwise synthesis infers a latch to hold the old value.
   always_comb begin
      state_d   = state_q;
      cmd       = CMD_NOP;
      alu_start = 1'b0;
      set_done  = 1'b0;
      set_err   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (i_valid) state_d = ST_SEL;
         end
         ST_SEL: begin
            cmd     = CMD_LATCHSEL;
            state_d = ST_RDA;
         end
         ST_RDA: begin
            cmd     = CMD_READA;
            state_d = use_b_q ? ST_RDB : ST_EXEC;
         end
         ST_RDB: begin
            cmd     = CMD_READB;
            state_d = ST_EXEC;
         end
         ST_EXEC: begin
            alu_start = (exec_cnt_q == '0);
            // ALU completion is checked before the timeout so a last-cycle done wins.
            if (i_alu_done) begin
               case (wsel_q)
                  WSEL_NONE: begin
                     state_d  = ST_IDLE;
                     set_done = 1'b1;
                  end
                  WSEL_RFU: begin
                     state_d = ST_IDLE;
                     set_err = 1'b1;
                  end
                  default: begin
                     if (write_to_zero) begin
                        state_d  = ST_IDLE;
                        set_done = 1'b1;
                     end else begin
                        state_d = ST_WB;
                     end
                  end
               endcase
            end else if (exec_cnt_q == EXEC_LAST) begin
               state_d = ST_IDLE;
               set_err = 1'b1;
            end
         end
         ST_WB: begin
            cmd      = ((wsel_q == WSEL_REGC) && (sel_c_q == R_SP)) ? CMD_SP_WE : CMD_ALU_WE;
            state_d  = ST_IDLE;
            set_done = 1'b1;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values of the others, independent of statement order.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= ST_IDLE;
         exec_cnt_q <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= set_done;
         err_q   <= set_err;
         if ((state_q == ST_EXEC) && (state_d == ST_EXEC)) begin
            exec_cnt_q <= exec_cnt_q + 1'b1;
         end else begin
            exec_cnt_q <= '0;
         end
      end
   end

   // Captured request fields stay stable for the whole op and after it, until
   // the next accept.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sel_a_q <= '0;
         sel_b_q <= '0;
         sel_c_q <= '0;
         use_b_q <= 1'b0;
         wsel_q  <= WSEL_NONE;
      end else if (accept) begin
         sel_a_q <= i_sel_a;
         sel_b_q <= i_sel_b;
         sel_c_q <= i_sel_c;
         use_b_q <= i_use_b;
         wsel_q  <= write_sel_t'(i_wsel);
      end
   end

   assign o_ready     = (state_q == ST_IDLE);
   assign o_cmd       = cmd;
   assign o_alu_start = alu_start;
   assign o_sel_a     = sel_a_q;
   assign o_sel_b     = sel_b_q;
   assign o_sel_c     = sel_c_q;
   assign o_alu_wsel  = wsel_q;
   assign o_done      = done_q;
   assign o_err       = err_q;

endmodule
